// File: rtl/cbus_reg_pkg.sv
// Shared address map and field definitions for the cbus register bank.
package cbus_reg_pkg;

    // Global register addresses
    localparam logic [11:0] ADDR_BOARD_TYPE   = 12'h000;
    localparam logic [11:0] ADDR_FPGA_VERSION = 12'h001;
    localparam logic [11:0] ADDR_SCRATCH      = 12'h002;
    localparam logic [11:0] ADDR_TEST_MODE    = 12'h003;
    localparam logic [11:0] ADDR_CHN_NUM      = 12'h004;

    // Per-channel slice placement
    localparam logic [11:0] CHN_BASE   = 12'h300;
    localparam int unsigned CHN_STRIDE = 4;

    // Register offsets inside a channel slice
    typedef enum logic [1:0] {
        CHN_OFF_CTRL    = 2'd0,
        CHN_OFF_STATUS  = 2'd1,
        CHN_OFF_RSVD    = 2'd2,
        CHN_OFF_EVT_CNT = 2'd3
    } chn_off_e;

    // CTRL register bit positions
    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_MODE_LSB   = 2;

    // Absolute address of a register inside channel chn
    function automatic logic [11:0] chn_reg_addr(input int unsigned chn, input chn_off_e off);
        return CHN_BASE + 12'(chn * CHN_STRIDE) + {10'b0, off};
    endfunction

endpackage

// File: rtl/cbus_rd_pipe.sv
// Read-request delay line: carries {valid, address} through DEPTH flop stages.
module cbus_rd_pipe #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    // Shift every stage forward by one slot
    always_comb begin
        vld_d     = '0;
        vld_d[0]  = in_vld;
        addr_d[0] = in_addr;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/cbus_reg_bank.sv
// CPU control-bus register bank: global ID/test registers, CHN_NUM channel
// control/status slices with sticky W1C event bits, level IRQ and a fixed
// read latency. Optional per-channel event counters under CBUS_EVT_CNT_EN.
module cbus_reg_bank
    import cbus_reg_pkg::*;
#(
    parameter int unsigned CBUS_ADDR_WIDTH = 12,
    parameter int unsigned CBUS_DATA_WIDTH = 8,
    parameter int unsigned CHN_NUM         = 4,
    parameter int unsigned RD_LATENCY      = 4,
    parameter logic [7:0]  BOARD_TYPE      = 8'h01,
    parameter logic [7:0]  FPGA_VERSION    = 8'h20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
    input  logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
    input  logic                       cbus_we,
    input  logic                       cbus_oe,
    output logic [CBUS_DATA_WIDTH-1:0] cbus_rdata,
    output logic                       cbus_rvld,
    input  logic [CHN_NUM-1:0]         chn_evt,
    output logic [CHN_NUM-1:0]         chn_enable,
    output logic [2*CHN_NUM-1:0]       chn_mode,
    output logic                       test_mode,
    output logic                       irq
);

    localparam int unsigned AW = CBUS_ADDR_WIDTH;
    localparam int unsigned DW = CBUS_DATA_WIDTH;

    logic [DW-1:0] scratch_q, scratch_d;
    logic          test_mode_q, test_mode_d;
    logic          rd_req_q, rd_req_d;
    logic [AW-1:0] rd_req_addr_q, rd_req_addr_d;
    logic          pipe_vld;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvld_q, rvld_d;
    logic          irq_q, irq_d;

    logic [CHN_NUM-1:0]   sticky_all;
    logic [CHN_NUM-1:0]   irq_en_all;
    logic [4*CHN_NUM-1:0] ctrl_all;
    logic [8*CHN_NUM-1:0] cnt_all;

    // Global register write decode
    always_comb begin
        scratch_d     = scratch_q;
        test_mode_d   = test_mode_q;
        rd_req_d      = cbus_oe;
        rd_req_addr_d = cbus_addr;
        if (cbus_we && (cbus_addr == AW'(ADDR_SCRATCH))) begin
            scratch_d = cbus_wdata;
        end
        if (cbus_we && (cbus_addr == AW'(ADDR_TEST_MODE))) begin
            test_mode_d = cbus_wdata[0];
        end
    end

    // Global registers and read-request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q     <= '0;
            test_mode_q   <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_req_addr_q <= '0;
        end else begin
            scratch_q     <= scratch_d;
            test_mode_q   <= test_mode_d;
            rd_req_q      <= rd_req_d;
            rd_req_addr_q <= rd_req_addr_d;
        end
    end

    // The capture flop plus RD_LATENCY-1 delay stages put the rdata load
    // exactly RD_LATENCY edges after the edge that sampled cbus_oe.
    cbus_rd_pipe #(
        .DEPTH  (RD_LATENCY - 1),
        .ADDR_W (AW)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd_req_q),
        .in_addr  (rd_req_addr_q),
        .out_vld  (pipe_vld),
        .out_addr (pipe_addr)
    );

    for (genvar gi = 0; gi < CHN_NUM; gi++) begin : g_chn
        logic [3:0] ctrl_q, ctrl_d;
        logic       sticky_q, sticky_d;
        logic       wr_ctrl, wr_status;

        // CTRL write and sticky event capture; a set wins over a same-cycle clear
        always_comb begin
            wr_ctrl   = cbus_we && (cbus_addr == AW'(chn_reg_addr(gi, CHN_OFF_CTRL)));
            wr_status = cbus_we && (cbus_addr == AW'(chn_reg_addr(gi, CHN_OFF_STATUS)));
            ctrl_d    = wr_ctrl ? cbus_wdata[3:0] : ctrl_q;
            sticky_d  = chn_evt[gi] | (sticky_q & ~(wr_status & cbus_wdata[0]));
        end

        // Channel control/status registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_q   <= '0;
                sticky_q <= 1'b0;
            end else begin
                ctrl_q   <= ctrl_d;
                sticky_q <= sticky_d;
            end
        end

        assign ctrl_all[4*gi +: 4]  = ctrl_q;
        assign sticky_all[gi]       = sticky_q;
        assign irq_en_all[gi]       = ctrl_q[CTRL_IRQ_EN_BIT];
        assign chn_enable[gi]       = ctrl_q[CTRL_ENABLE_BIT];
        assign chn_mode[2*gi +: 2]  = ctrl_q[CTRL_MODE_LSB +: 2];

`ifdef CBUS_EVT_CNT_EN
        logic [7:0] evt_cnt_q, evt_cnt_d;
        logic       wr_evt_cnt;

        // Saturating event count; a clear with a same-cycle event restarts at 1
        always_comb begin
            wr_evt_cnt = cbus_we && (cbus_addr == AW'(chn_reg_addr(gi, CHN_OFF_EVT_CNT)));
            evt_cnt_d  = evt_cnt_q;
            if (wr_evt_cnt) begin
                evt_cnt_d = chn_evt[gi] ? 8'h01 : 8'h00;
            end else if (chn_evt[gi] && (evt_cnt_q != 8'hFF)) begin
                evt_cnt_d = evt_cnt_q + 8'h01;
            end
        end

        // Event counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                evt_cnt_q <= '0;
            end else begin
                evt_cnt_q <= evt_cnt_d;
            end
        end

        assign cnt_all[8*gi +: 8] = evt_cnt_q;
`else
        assign cnt_all[8*gi +: 8] = '0;
`endif
    end

    // Read data multiplexer, addressed by the request leaving the delay line
    always_comb begin
        rd_mux = '0;
        if (pipe_addr == AW'(ADDR_BOARD_TYPE)) begin
            rd_mux = DW'(BOARD_TYPE);
        end else if (pipe_addr == AW'(ADDR_FPGA_VERSION)) begin
            rd_mux = DW'(FPGA_VERSION);
        end else if (pipe_addr == AW'(ADDR_SCRATCH)) begin
            rd_mux = ~scratch_q;
        end else if (pipe_addr == AW'(ADDR_TEST_MODE)) begin
            rd_mux = DW'(test_mode_q);
        end else if (pipe_addr == AW'(ADDR_CHN_NUM)) begin
            rd_mux = DW'(CHN_NUM);
        end
        for (int unsigned i = 0; i < CHN_NUM; i++) begin
            if (pipe_addr == AW'(chn_reg_addr(i, CHN_OFF_CTRL))) begin
                rd_mux = DW'(ctrl_all[4*i +: 4]);
            end else if (pipe_addr == AW'(chn_reg_addr(i, CHN_OFF_STATUS))) begin
                rd_mux = DW'(sticky_all[i]);
            end else if (pipe_addr == AW'(chn_reg_addr(i, CHN_OFF_EVT_CNT))) begin
                rd_mux = DW'(cnt_all[8*i +: 8]);
            end
        end
    end

    // Read response and interrupt next-state
    always_comb begin
        rvld_d  = pipe_vld;
        rdata_d = pipe_vld ? rd_mux : rdata_q;
        irq_d   = |(sticky_all & irq_en_all);
    end

    // Read response and interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            irq_q   <= irq_d;
        end
    end

    assign cbus_rdata = rdata_q;
    assign cbus_rvld  = rvld_q;
    assign test_mode  = test_mode_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_cbus_reg_bank.sv
// Scoreboard bench for cbus_reg_bank: a driver updates an address-map model
// and queues expected read data and per-cycle outputs; a monitor compares.
`timescale 1ns/1ps
module tb_cbus_reg_bank;

    localparam int AW  = 12;
    localparam int CHN = 4;
    localparam int RL  = 4;
    localparam logic [7:0] BT = 8'h01;
    localparam logic [7:0] FV = 8'h20;
`ifdef CBUS_EVT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  cbus_addr = '0;
    logic [7:0]     cbus_wdata = '0;
    logic           cbus_we = 1'b0;
    logic           cbus_oe = 1'b0;
    logic [7:0]     cbus_rdata;
    logic           cbus_rvld;
    logic [CHN-1:0] chn_evt = '0;
    logic [CHN-1:0] chn_enable;
    logic [2*CHN-1:0] chn_mode;
    logic           test_mode;
    logic           irq;

    always #5 clk = ~clk;

    cbus_reg_bank #(
        .CBUS_ADDR_WIDTH (AW),
        .CBUS_DATA_WIDTH (8),
        .CHN_NUM         (CHN),
        .RD_LATENCY      (RL),
        .BOARD_TYPE      (BT),
        .FPGA_VERSION    (FV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cbus_addr  (cbus_addr),
        .cbus_wdata (cbus_wdata),
        .cbus_we    (cbus_we),
        .cbus_oe    (cbus_oe),
        .cbus_rdata (cbus_rdata),
        .cbus_rvld  (cbus_rvld),
        .chn_evt    (chn_evt),
        .chn_enable (chn_enable),
        .chn_mode   (chn_mode),
        .test_mode  (test_mode),
        .irq        (irq)
    );

    typedef struct {
        logic [CHN-1:0]   en;
        logic [2*CHN-1:0] mode;
        logic             tm;
        logic             irq;
        logic [7:0]       rdata;
    } out_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } rd_req_t;

    logic [7:0] exp_rd_q [$];
    out_t       exp_out_q [$];
    rd_req_t    pend_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: register contents as plain variables
    logic [7:0] m_scratch;
    logic       m_tm;
    logic [3:0] m_ctrl [CHN];
    logic       m_sticky [CHN];
    int         m_cnt [CHN];
    logic [7:0] m_rdata;
    logic       m_irq;

    task automatic model_reset();
        m_scratch = 8'h00;
        m_tm      = 1'b0;
        m_rdata   = 8'h00;
        m_irq     = 1'b0;
        for (int c = 0; c < CHN; c++) begin
            m_ctrl[c]   = 4'h0;
            m_sticky[c] = 1'b0;
            m_cnt[c]    = 0;
        end
        pend_q.delete();
    endtask

    function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
        int ai;
        int idx;
        int off;
        ai = int'(a);
        case (ai)
            0: return BT;
            1: return FV;
            2: return ~m_scratch;
            3: return {7'b0, m_tm};
            4: return 8'(CHN);
            default: ;
        endcase
        if (ai >= 'h300 && ai < 'h300 + 4 * CHN) begin
            idx = (ai - 'h300) / 4;
            off = ai % 4;
            case (off)
                0: return {4'b0, m_ctrl[idx]};
                1: return {7'b0, m_sticky[idx]};
                3: return CNT_EN ? 8'(m_cnt[idx]) : 8'h00;
                default: return 8'h00;
            endcase
        end
        return 8'h00;
    endfunction

    // Drive one cycle of inputs, let one edge happen, advance the model
    task automatic step(input logic we, input logic oe, input logic [AW-1:0] a,
                        input logic [7:0] wd, input logic [CHN-1:0] evt);
        logic    irq_next;
        logic    in_chn;
        int      ai;
        int      idx;
        int      off;
        rd_req_t r;
        out_t    o;
        cbus_we    = we;
        cbus_oe    = oe;
        cbus_addr  = a;
        cbus_wdata = wd;
        chn_evt    = evt;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            irq_next = 1'b0;
            for (int c = 0; c < CHN; c++) begin
                if (m_sticky[c] && m_ctrl[c][1]) irq_next = 1'b1;
            end
            while (pend_q.size() > 0 && pend_q[0].cyc + RL == cyc) begin
                r = pend_q.pop_front();
                m_rdata = ref_read(r.addr);
                exp_rd_q.push_back(m_rdata);
            end
            if (oe) begin
                r.addr = a;
                r.cyc  = cyc;
                pend_q.push_back(r);
            end
            ai     = int'(a);
            in_chn = we && ai >= 'h300 && ai < 'h300 + 4 * CHN;
            idx    = (ai - 'h300) / 4;
            off    = ai % 4;
            if (we && ai == 2) m_scratch = wd;
            if (we && ai == 3) m_tm = wd[0];
            for (int c = 0; c < CHN; c++) begin
                if (in_chn && idx == c && off == 0) m_ctrl[c] = wd[3:0];
                if (evt[c]) m_sticky[c] = 1'b1;
                else if (in_chn && idx == c && off == 1 && wd[0]) m_sticky[c] = 1'b0;
                if (CNT_EN) begin
                    if (in_chn && idx == c && off == 3) m_cnt[c] = evt[c] ? 1 : 0;
                    else if (evt[c] && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
                end
            end
            m_irq = irq_next;
        end
        for (int c = 0; c < CHN; c++) begin
            o.en[c]         = m_ctrl[c][0];
            o.mode[2*c +: 2] = m_ctrl[c][3:2];
        end
        o.tm    = m_tm;
        o.irq   = m_irq;
        o.rdata = m_rdata;
        exp_out_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 8'h00, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b1, a, 8'h00, '0);
    endtask

    // Reset changes land just after the monitor has sampled
    task automatic set_reset(input logic v);
        @(negedge clk);
        #1;
        rst_n = v;
        if (!v) begin
            model_reset();
            exp_rd_q.delete();
        end
    endtask

    // Monitor: read responses and per-cycle outputs
    initial begin
        logic [7:0] e;
        out_t       o;
        forever begin
            @(negedge clk);
            if (cbus_rvld) begin
                n_tests++;
                if (exp_rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvld_unexpected: cyc=%0d rvld=1 rdata=%h, required rvld=0", cyc, cbus_rdata);
                end else begin
                    e = exp_rd_q.pop_front();
                    if (cbus_rdata !== e) begin
                        n_fail++;
                        $display("FAIL rdata: cyc=%0d got %h, required %h", cyc, cbus_rdata, e);
                    end
                end
            end else if (exp_rd_q.size() > 0) begin
                n_tests++;
                n_fail++;
                e = exp_rd_q.pop_front();
                $display("FAIL rvld_missing: cyc=%0d rvld=0, required rvld=1 with rdata %h", cyc, e);
            end
            if (exp_out_q.size() > 0) begin
                o = exp_out_q.pop_front();
                n_tests++;
                if (chn_enable !== o.en || chn_mode !== o.mode || test_mode !== o.tm ||
                    irq !== o.irq || cbus_rdata !== o.rdata) begin
                    n_fail++;
                    $display("FAIL outputs: cyc=%0d got en=%h mode=%h tm=%b irq=%b rdata=%h, required en=%h mode=%h tm=%b irq=%b rdata=%h",
                             cyc, chn_enable, chn_mode, test_mode, irq, cbus_rdata,
                             o.en, o.mode, o.tm, o.irq, o.rdata);
                end
            end
        end
    end

    // Time bound on the whole run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by random traffic
    initial begin
        logic           we;
        logic           oe;
        logic [AW-1:0]  a;
        logic [7:0]     d;
        logic [CHN-1:0] ev;
        int             sel;

        model_reset();
        idle(3);
        set_reset(1'b1);
        idle(2);

        // ID registers
        rd(12'h000); idle(1);
        rd(12'h001); idle(1);
        rd(12'h004); idle(RL + 1);

        // Scratch inversion and unmapped read
        wr(12'h002, 8'h5A);
        rd(12'h002);
        rd(12'h7FF);
        idle(RL + 1);

        // Channel 1 enable/mode without irq_en
        wr(12'h304, 8'h0D);
        idle(3);

        // Channel 0 event, irq, W1C, and set-wins-over-clear
        wr(12'h300, 8'h02);
        step(1'b0, 1'b0, '0, 8'h00, 4'b0001);
        rd(12'h301);
        idle(2);
        wr(12'h301, 8'h01);
        idle(2);
        step(1'b1, 1'b0, 12'h301, 8'h01, 4'b0001);
        rd(12'h301);
        idle(RL + 2);

        // Same-cycle write and read of scratch
        step(1'b1, 1'b1, 12'h002, 8'h3C, '0);
        idle(RL + 1);

        // Back-to-back reads, then reset with reads still in flight
        rd(12'h000); rd(12'h001); rd(12'h002); rd(12'h003);
        idle(RL + 1);
        rd(12'h000); rd(12'h001); rd(12'h002); rd(12'h003);
        idle(1);
        set_reset(1'b0);
        idle(3);
        set_reset(1'b1);
        idle(RL + 4);

        // Event counter saturation and clear-with-event on channel 2
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, '0, 8'h00, 4'b0100);
        rd(12'h30B);
        idle(1);
        step(1'b1, 1'b0, 12'h30B, 8'h00, 4'b0100);
        rd(12'h30B);
        idle(RL + 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      a = AW'($urandom_range(0, 7));
            else if (sel < 9) a = AW'('h300 + $urandom_range(0, 63));
            else              a = AW'($urandom);
            we = ($urandom_range(0, 9) < 4);
            oe = ($urandom_range(0, 1) == 1);
            d  = 8'($urandom);
            for (int c = 0; c < CHN; c++) ev[c] = ($urandom_range(0, 3) == 0);
            step(we, oe, a, d, ev);
        end
        idle(RL + 3);

        n_tests++;
        if (exp_rd_q.size() != 0 || pend_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses and %0d requests outstanding, required 0",
                     exp_rd_q.size(), pend_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
